object_plotter: RTL and testbench

//   Rasteriser between the game-logic stage and the VGA adapter. On each start_plot pulse it latches
//   one object's rectangle update, erases the old rectangle in background colour, then draws the new
//   one in the object's colour. It emits one pixel write per clock on the adapter's x/y/colour/plot bus.

---
 rtl/object_plotter.sv | 179 +++++++++++++++++
 tb/tb_object_plotter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/object_plotter.sv
// Erase-then-draw rectangle rasteriser feeding the VGA adapter.
// One pixel write per clock; all outputs registered.
module object_plotter #(
  parameter logic [7:0] MAX_X         = 8'd159,
  parameter logic [6:0] MAX_Y         = 7'd119,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] BALL_COLOUR   = 3'b111,
  parameter logic [2:0] PADDLE_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_plot,
  input  logic [1:0] object,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [7:0] old_x,
  input  logic [6:0] old_y,
  input  logic [7:0] size_x,
  input  logic [6:0] size_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    FIN
  } state_t;

  state_t     state, stateNext;
  logic [7:0] cx, cxNext;
  logic [6:0] cy, cyNext;
  logic [1:0] obj, objNext;
  logic [7:0] nx, nxNext, ox, oxNext, sx, sxNext;
  logic [6:0] ny, nyNext, oy, oyNext, sy, syNext;

  logic       accept;
  logic       lastX, lastY;
  logic [7:0] baseX;
  logic [6:0] baseY;
  logic [8:0] sumX;
  logic [7:0] sumY;
  logic       plotNext;
  logic [2:0] colNext;

  assign accept = start_plot && (state == IDLE)
                  && (object != 2'b11);
  assign lastX  = (cx == sx - 8'd1);
  assign lastY  = (cy == sy - 7'd1);

  always_comb begin
    objNext = obj;
    nxNext  = nx;
    nyNext  = ny;
    oxNext  = ox;
    oyNext  = oy;
    sxNext  = sx;
    syNext  = sy;
    if (accept) begin
      objNext = object;
      nxNext  = new_x;
      nyNext  = new_y;
      oxNext  = old_x;
      oyNext  = old_y;
      sxNext  = size_x;
      syNext  = size_y;
    end
  end

  always_comb begin
    stateNext = state;
    cxNext    = cx;
    cyNext    = cy;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cxNext = 8'd0;
          cyNext = 7'd0;
          if (size_x == 8'd0 || size_y == 7'd0)
            stateNext = FIN;
          else
            stateNext = ERASE;
        end
      end
      ERASE, DRAW: begin
        if (lastX) begin
          cxNext = 8'd0;
          if (lastY) begin
            cyNext = 7'd0;
            // bricks have no draw phase
            if (state == DRAW || obj == 2'b10)
              stateNext = FIN;
            else
              stateNext = DRAW;
          end else begin
            cyNext = cy + 7'd1;
          end
        end else begin
          cxNext = cx + 8'd1;
        end
      end
      FIN: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output registers are loaded from the next scan position
  always_comb begin
    baseX = nxNext;
    baseY = nyNext;
    if (stateNext == ERASE && objNext != 2'b10) begin
      baseX = oxNext;
      baseY = oyNext;
    end
    sumX = {1'b0, baseX} + {1'b0, cxNext};
    sumY = {1'b0, baseY} + {1'b0, cyNext};
    plotNext = (stateNext == ERASE || stateNext == DRAW)
               && (sumX <= {1'b0, MAX_X})
               && (sumY <= {1'b0, MAX_Y});
    colNext = BG_COLOUR;
    if (stateNext == DRAW) begin
      unique case (1'b1)
        (objNext == 2'b00): colNext = BALL_COLOUR;
        (objNext == 2'b01): colNext = PADDLE_COLOUR;
        default:            colNext = BG_COLOUR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cx         <= 8'd0;
      cy         <= 7'd0;
      obj        <= 2'b00;
      nx         <= 8'd0;
      ny         <= 7'd0;
      ox         <= 8'd0;
      oy         <= 7'd0;
      sx         <= 8'd0;
      sy         <= 7'd0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'b000;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state    <= stateNext;
      cx       <= cxNext;
      cy       <= cyNext;
      obj      <= objNext;
      nx       <= nxNext;
      ny       <= nyNext;
      ox       <= oxNext;
      oy       <= oyNext;
      sx       <= sxNext;
      sy       <= syNext;
      vga_plot <= plotNext;
      busy     <= (stateNext != IDLE);
      done     <= (stateNext == FIN);
      if (plotNext) begin
        vga_x      <= sumX[7:0];
        vga_y      <= sumY[6:0];
        vga_colour <= colNext;
      end
      if (start_plot && state != IDLE)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_object_plotter.sv
// Directed scoreboard bench for object_plotter.
// Expected per-cycle pixels are queued at start and popped each cycle.
module tb_object_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_plot = 1'b0;
  logic [1:0] object = 2'b11;
  logic [7:0] new_x = '0, old_x = '0, size_x = '0;
  logic [6:0] new_y = '0, old_y = '0, size_y = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done, overrun;

  typedef struct packed {
    logic       p;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  logic expOvr = 1'b0;

  always #5 clk = ~clk;

  object_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_plot (start_plot),
    .object     (object),
    .new_x      (new_x),
    .new_y      (new_y),
    .old_x      (old_x),
    .old_y      (old_y),
    .size_x     (size_x),
    .size_y     (size_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_phase(input int bx, input int by,
                            input int w, input int h,
                            input logic [2:0] col);
    pix_t e;
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        e.p = (bx + i <= 159) && (by + j <= 119);
        e.x = 8'(bx + i);
        e.y = 7'(by + j);
        e.c = col;
        q.push_back(e);
      end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_plot"}, 32'(vga_plot), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_job(input logic [1:0] o,
                         input logic [7:0] nX,
                         input logic [6:0] nY,
                         input logic [7:0] oX,
                         input logic [6:0] oY,
                         input logic [7:0] sX,
                         input logic [6:0] sY,
                         input int hitAt,
                         input int rstAt);
    pix_t e;
    int   i;
    q.delete();
    if (o == 2'b10) begin
      push_phase(nX, nY, sX, sY, 3'b000);
    end else begin
      push_phase(oX, oY, sX, sY, 3'b000);
      push_phase(nX, nY, sX, sY,
                 (o == 2'b00) ? 3'b111 : 3'b010);
    end
    @(negedge clk);
    object = o;
    new_x = nX; new_y = nY;
    old_x = oX; old_y = oY;
    size_x = sX; size_y = sY;
    start_plot = 1'b1;
    @(negedge clk);
    start_plot = 1'b0;
    new_x = 8'd3; new_y = 7'd2;
    old_x = 8'd1; old_y = 7'd1;
    size_x = 8'd2; size_y = 7'd2;
    object = 2'b01;
    i = 0;
    while (q.size() > 0) begin
      if (i == rstAt) begin
        resetn = 1'b0;
        #1;
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x", 32'(vga_x), 32'd0);
        chk("rst_y", 32'(vga_y), 32'd0);
        chk("rst_col", 32'(vga_colour), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        expOvr = 1'b0;
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          idle_chk("post_rst");
        end
        return;
      end
      e = q.pop_front();
      chk("plot", 32'(vga_plot), 32'(e.p));
      if (e.p) begin
        chk("x", 32'(vga_x), 32'(e.x));
        chk("y", 32'(vga_y), 32'(e.y));
        chk("colour", 32'(vga_colour), 32'(e.c));
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (i == hitAt) begin
        start_plot = 1'b1;
        object = 2'b00;
        expOvr = 1'b1;
      end
      @(negedge clk);
      start_plot = 1'b0;
      i++;
    end
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_plot", 32'(vga_plot), 32'd0);
    @(negedge clk);
    chk("end_done", 32'(done), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("overrun", 32'(overrun), 32'(expOvr));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    idle_chk("reset");
    chk("reset_ovr", 32'(overrun), 32'd0);
    chk("reset_x", 32'(vga_x), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    idle_chk("released");

    // ball
    run_job(2'b00, 8'd51, 7'd5, 8'd50, 7'd4,
            8'd4, 7'd4, -1, -1);
    // paddle
    run_job(2'b01, 8'd99, 7'd117, 8'd100, 7'd117,
            8'd20, 7'd1, -1, -1);
    // brick: old position must be ignored
    run_job(2'b10, 8'd16, 7'd10, 8'd90, 7'd90,
            8'd16, 7'd10, -1, -1);
    // clipping at bottom-right corner
    run_job(2'b00, 8'd158, 7'd118, 8'd158, 7'd118,
            8'd4, 7'd4, -1, -1);
    // zero size
    run_job(2'b00, 8'd10, 7'd10, 8'd20, 7'd20,
            8'd0, 7'd5, -1, -1);

    // object none is ignored
    @(negedge clk);
    object = 2'b11;
    size_x = 8'd4; size_y = 7'd4;
    start_plot = 1'b1;
    @(negedge clk);
    start_plot = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle_chk("none");
      @(negedge clk);
    end
    chk("none_ovr", 32'(overrun), 32'd0);

    // start during ERASE
    run_job(2'b00, 8'd30, 7'd30, 8'd29, 7'd29,
            8'd3, 7'd3, 3, -1);
    // overrun stays sticky
    run_job(2'b01, 8'd0, 7'd0, 8'd1, 7'd1,
            8'd2, 7'd2, -1, -1);
    // reset mid-job
    run_job(2'b00, 8'd51, 7'd5, 8'd50, 7'd4,
            8'd4, 7'd4, -1, 7);
    run_job(2'b01, 8'd60, 7'd60, 8'd61, 7'd61,
            8'd5, 7'd2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
